// File: rtl/conv_input_pad_writer.sv
// conv_input_pad_writer
//
// Feeds the layer-0 input FIFO with a zero-padded image. A raw WIDTH x WIDTH
// RGB image arrives as a valid/ready pixel stream. The block writes the
// (WIDTH+2) x (WIDTH+2) frame in raster order, with a one-pixel zero border
// around the image, and respects FIFO back-pressure.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        single-cycle frame start, honoured only while idle
//   pixel_in     unpadded pixel, B [3DW-1:2DW], G [2DW-1:DW], R [DW-1:0]
//   pixel_valid  pixel_in holds a valid pixel
//   pixel_ready  pixel consumed this cycle when pixel_valid & pixel_ready
//   fifo_full    downstream FIFO is full
//   wrreq        FIFO write strobe, one word per asserted cycle
//   data_out     FIFO write data, same B/G/R packing as pixel_in
//   busy         frame in progress (STREAM or DONE)
//   frame_done   one-cycle pulse after the final padded word is written
module conv_input_pad_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3*DATA_WIDTH-1:0] pixel_in,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  input  logic                    fifo_full,
  output logic                    wrreq,
  output logic [3*DATA_WIDTH-1:0] data_out,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] row, col, row_next, col_next;
  logic          border;

  // The padded ring: the first and last row and column of the padded frame.
  assign border = (row == '0) || (row == LAST) || (col == '0) || (col == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge, whatever order the statements
  // are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_next;
      row   <= row_next;
      col   <= col_next;
    end
  end

  // Outputs are combinational. A word is offered and accepted in the same
  // cycle, so back-pressure takes effect with no delay.
  always_comb begin
    // NOTE: every signal gets a default first. Without it, a path that does
    // not assign the signal would infer a latch.
    state_next  = state;
    row_next    = row;
    col_next    = col;
    wrreq       = 1'b0;
    pixel_ready = 1'b0;
    data_out    = '0;
    busy        = (state != IDLE);
    frame_done  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = STREAM;
          row_next   = '0;
          col_next   = '0;
        end
      end

      STREAM: begin
        if (border) begin
          // Zero words never wait for the pixel stream.
          wrreq = ~fifo_full;
        end else begin
          pixel_ready = ~fifo_full;
          wrreq       = pixel_valid & ~fifo_full;
          data_out    = pixel_in;
        end

        // The position moves only when a word is actually written.
        if (wrreq) begin
          if (col == LAST) begin
            col_next = '0;
            if (row == LAST) begin
              row_next   = '0;
              state_next = DONE;
            end else begin
              row_next = row + 1'b1;
            end
          end else begin
            col_next = col + 1'b1;
          end
        end
      end

      DONE: begin
        // A start pulse here is ignored. The next frame needs a fresh pulse
        // while idle.
        frame_done = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_input_pad_writer.sv
// Testbench for conv_input_pad_writer: a WIDTH=4 instance for the directed
// scenarios and a WIDTH=112 instance for one randomized full frame. The
// expected word stream is built from the padded-frame definition: zero on the
// ring, and the next unpadded pixel in raster order everywhere else.
module tb_conv_input_pad_writer;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int SP = SW + 2;
  localparam int SN = SP * SP;
  localparam int BW = 112;
  localparam int BP = BW + 2;
  localparam int BN = BP * BP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          s_start, s_valid, s_ready, s_full, s_wrreq, s_busy, s_done;
  logic [3*DW-1:0] s_pix, s_data;
  logic          b_start, b_valid, b_ready, b_full, b_wrreq, b_busy, b_done;
  logic [3*DW-1:0] b_pix, b_data;

  conv_input_pad_writer #(.DATA_WIDTH(DW), .WIDTH(SW)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .pixel_in(s_pix),
    .pixel_valid(s_valid), .pixel_ready(s_ready), .fifo_full(s_full),
    .wrreq(s_wrreq), .data_out(s_data), .busy(s_busy), .frame_done(s_done)
  );

  conv_input_pad_writer #(.DATA_WIDTH(DW), .WIDTH(BW)) dut_big (
    .clk(clk), .rst(rst), .start(b_start), .pixel_in(b_pix),
    .pixel_valid(b_valid), .pixel_ready(b_ready), .fifo_full(b_full),
    .wrreq(b_wrreq), .data_out(b_data), .busy(b_busy), .frame_done(b_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [3*DW-1:0] got,
                       input logic [3*DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- WIDTH=4 model and driver ----------------
  logic [3*DW-1:0] s_pq[$];
  logic [3*DW-1:0] s_exp[SN];
  logic [3*DW-1:0] s_obs[SN];
  int  s_widx, s_hs, s_dones, s_cyc, s_first, s_last, s_donecyc;
  bit  s_prev_done;

  task automatic s_load(input bit ramp);
    s_pq.delete();
    for (int i = 0; i < SW * SW; i++)
      s_pq.push_back(ramp ? (3*DW)'(i + 1) : {$urandom, $urandom, $urandom} | 96'h1);
    for (int p = 0; p < SN; p++) begin
      int r, c;
      r = p / SP;
      c = p % SP;
      if (r == 0 || r == SP - 1 || c == 0 || c == SP - 1) s_exp[p] = '0;
      else s_exp[p] = s_pq[(r - 1) * SW + (c - 1)];
      s_obs[p] = 'x;
    end
    s_widx = 0; s_hs = 0; s_dones = 0; s_cyc = 0;
    s_first = -1; s_last = -1; s_donecyc = -1; s_prev_done = 1'b0;
  endtask

  // One cycle: drive at the negedge, sample 1ns later, then wait for the next negedge.
  task automatic s_step(input bit st, input bit full, input bit valid);
    s_start = st;
    s_full  = full;
    s_valid = valid && (s_pq.size() > 0);
    s_pix   = s_valid ? s_pq[0] : {$urandom, $urandom, $urandom};
    #1;
    if (s_prev_done) check("busy_after_done", s_busy, 0);
    s_prev_done = s_done;
    if (full) begin
      check("full_wrreq", s_wrreq, 0);
      check("full_ready", s_ready, 0);
    end
    if (s_wrreq) begin
      if (s_widx < SN) begin
        check($sformatf("word%0d", s_widx), s_data, s_exp[s_widx]);
        s_obs[s_widx] = s_data;
      end else begin
        check("extra_write", s_wrreq, 0);
      end
      if (s_widx == 0) s_first = s_cyc;
      s_last = s_cyc;
      s_widx++;
    end
    if (s_valid && s_ready) begin
      void'(s_pq.pop_front());
      s_hs++;
    end
    if (s_done) begin
      s_dones++;
      s_donecyc = s_cyc;
    end
    s_cyc++;
    @(negedge clk);
  endtask

  // mode 0 clean, 1 full hold at word 9, 2 valid toggling, 3 extra starts,
  // 4 random stalls, 5 reset after 20 writes
  task automatic s_frame(input int mode);
    int  hold, tail;
    bit  st, full, valid, aborted;
    s_load(mode != 4);
    hold = 0; tail = 0; aborted = 1'b0;
    s_step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 1000; k++) begin
      if (s_dones > 0) begin
        tail++;
        if (tail > 3) break;
      end
      st = 1'b0; full = 1'b0; valid = 1'b1;
      case (mode)
        1: if (s_widx == 9 && hold < 5) begin full = 1'b1; hold++; end
        2: valid = (k % 2) == 0;
        3: st = (s_widx == 15) || (s_widx == SN && s_dones == 0);
        4: begin
          full  = ($urandom_range(0, 3) == 0);
          valid = ($urandom_range(0, 3) != 0);
        end
        default: ;
      endcase
      if (mode == 5 && s_widx == 20) begin
        rst = 1'b1;
        s_step(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        s_start = 1'b0; s_full = 1'b0; s_valid = 1'b1;
        #1;
        check("rst_wrreq", s_wrreq, 0);
        check("rst_busy", s_busy, 0);
        check("rst_ready", s_ready, 0);
        check("rst_data", s_data, 0);
        check("rst_done", s_done, 0);
        @(negedge clk);
        aborted = 1'b1;
        break;
      end
      s_step(st, full, valid);
    end
    if (!aborted) begin
      check("writes", s_widx, SN);
      check("handshakes", s_hs, SW * SW);
      check("frame_done_count", s_dones, 1);
      check("done_after_last", s_donecyc, s_last + 1);
      if (mode == 0) begin
        check("first_write_cycle", s_first, 1);
        check("last_write_cycle", s_last, SN);
        check("word7_is_pixel1", s_obs[7], 1);
        check("word10_is_pixel4", s_obs[10], 4);
        check("word28_is_pixel16", s_obs[28], 16);
      end
      if (mode == 1) check("word9_is_pixel3", s_obs[9], 3);
    end
  endtask

  // ---------------- WIDTH=112 randomized frame ----------------
  logic [3*DW-1:0] b_pq[$];
  logic [3*DW-1:0] b_exp[BN];

  task automatic b_frame();
    int widx, hs, dones, zeros, tail;
    bit full, valid;
    b_pq.delete();
    for (int i = 0; i < BW * BW; i++)
      b_pq.push_back({$urandom, $urandom, $urandom} | 96'h1);
    for (int p = 0; p < BN; p++) begin
      int r, c;
      r = p / BP;
      c = p % BP;
      if (r == 0 || r == BP - 1 || c == 0 || c == BP - 1) b_exp[p] = '0;
      else b_exp[p] = b_pq[(r - 1) * BW + (c - 1)];
    end
    widx = 0; hs = 0; dones = 0; zeros = 0; tail = 0;
    b_start = 1'b1; b_full = 1'b0; b_valid = 1'b0; b_pix = '0;
    @(negedge clk);
    b_start = 1'b0;
    for (int k = 0; k < 60000; k++) begin
      if (dones > 0) begin
        tail++;
        if (tail > 3) break;
      end
      full    = ($urandom_range(0, 4) == 0);
      valid   = ($urandom_range(0, 4) != 0) && (b_pq.size() > 0);
      b_full  = full;
      b_valid = valid;
      b_pix   = valid ? b_pq[0] : {$urandom, $urandom, $urandom};
      #1;
      if (b_wrreq) begin
        if (widx < BN) check("big_word", b_data, b_exp[widx]);
        else check("big_extra_write", b_wrreq, 0);
        if (b_data == '0) zeros++;
        widx++;
      end
      if (b_valid && b_ready) begin
        void'(b_pq.pop_front());
        hs++;
      end
      if (b_done) dones++;
      @(negedge clk);
    end
    check("big_writes", widx, BN);
    check("big_zero_words", zeros, 4 * BW + 4);
    check("big_handshakes", hs, BW * BW);
    check("big_frame_done_count", dones, 1);
    check("big_busy_end", b_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    s_start = 1'b0; s_valid = 1'b0; s_full = 1'b0; s_pix = '0;
    b_start = 1'b0; b_valid = 1'b0; b_full = 1'b0; b_pix = '0;
    repeat (3) @(negedge clk);
    s_valid = 1'b1;
    #1;
    check("reset_wrreq", s_wrreq, 0);
    check("reset_ready", s_ready, 0);
    check("reset_data", s_data, 0);
    check("reset_busy", s_busy, 0);
    check("reset_done", s_done, 0);
    check("reset_big_busy", b_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    s_frame(0);
    s_frame(1);
    s_frame(2);
    s_frame(3);
    s_frame(5);
    s_frame(0);
    s_frame(4);
    b_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
